// File: rtl/sprite_fetch.sv
// rtl/sprite_fetch.sv - Pac-Man sprite hit test, frameRAM address and walk animation.
// Define SPRITE_MIRROR_EN to fetch dir=2 (left) as the mirrored dir=0 row.
module sprite_fetch #(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16,
    parameter int FRAMES   = 4,
    parameter int ANIM_DIV = 8,
    parameter int IDX_W    = 4,
    parameter int ADDR_W   = 12
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_start,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic [9:0]        SpriteX,
    input  logic [9:0]        SpriteY,
    input  logic [1:0]        dir,
    input  logic              moving,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [IDX_W-1:0]  ram_data,
    output logic              pix_valid,
    output logic [IDX_W-1:0]  pix_idx
);

    localparam int LF = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int LD = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [10:0] LP_W = 11'(SPRITE_W);
    localparam logic [10:0] LP_H = 11'(SPRITE_H);

    logic [9:0]        r_sx;
    logic [9:0]        r_sy;
    logic [1:0]        r_dir;
    logic [LF-1:0]     r_anim;
    logic [LD-1:0]     r_div;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_hit_d;
    logic              r_pix_valid;
    logic [IDX_W-1:0]  r_pix_idx;

    logic [10:0]       w_dx;
    logic [10:0]       w_dy;
    logic              w_hit;
    logic [1:0]        w_row;
    logic [10:0]       w_dx_eff;
    logic [ADDR_W-1:0] w_addr;

    // A borrow sets bit 10, so one unsigned compare covers both "left of box" and "past box".
    assign w_dx  = {1'b0, DrawX} - {1'b0, r_sx};
    assign w_dy  = {1'b0, DrawY} - {1'b0, r_sy};
    assign w_hit = (w_dx < LP_W) && (w_dy < LP_H);

`ifdef SPRITE_MIRROR_EN
    assign w_row    = (r_dir == 2'd2) ? 2'd0 : r_dir;
    assign w_dx_eff = (r_dir == 2'd2) ? (LP_W - 11'd1 - w_dx) : w_dx;
`else
    assign w_row    = r_dir;
    assign w_dx_eff = w_dx;
`endif

    assign w_addr = ADDR_W'(((32'(w_row) * SPRITE_H + 32'(w_dy)) * FRAMES + 32'(r_anim))
                            * SPRITE_W + 32'(w_dx_eff));

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sx   <= '0;
            r_sy   <= '0;
            r_dir  <= '0;
            r_anim <= '0;
            r_div  <= '0;
        end else if (frame_start) begin
            r_sx  <= SpriteX;
            r_sy  <= SpriteY;
            r_dir <= dir;
            if (moving) begin
                if (r_div == LD'(ANIM_DIV - 1)) begin
                    r_div  <= '0;
                    r_anim <= (r_anim == LF'(FRAMES - 1)) ? '0 : r_anim + 1'b1;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ram_addr  <= '0;
            r_hit_d     <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pix_idx   <= '0;
        end else begin
            r_ram_addr  <= w_hit ? w_addr : '0;
            r_hit_d     <= w_hit;
            r_pix_valid <= r_hit_d && (ram_data != '0);
            r_pix_idx   <= r_hit_d ? ram_data : '0;
        end
    end

    assign ram_addr  = r_ram_addr;
    assign pix_valid = r_pix_valid;
    assign pix_idx   = r_pix_idx;

endmodule

// File: tb/tb_sprite_fetch.sv
// tb/tb_sprite_fetch.sv - directed bench for sprite_fetch (honours SPRITE_MIRROR_EN).
module tb_sprite_fetch;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_start;
    logic [9:0]  DrawX, DrawY, SpriteX, SpriteY;
    logic [1:0]  dir;
    logic        moving;
    logic [11:0] ram_addr;
    logic [3:0]  ram_data;
    logic        pix_valid;
    logic [3:0]  pix_idx;

    int n_total = 0;
    int n_pass  = 0;

    sprite_fetch dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .SpriteX(SpriteX), .SpriteY(SpriteY),
        .dir(dir), .moving(moving), .ram_addr(ram_addr), .ram_data(ram_data),
        .pix_valid(pix_valid), .pix_idx(pix_idx)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        @(posedge Clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic probe(input string tag, input int x, input int y, input int d,
                         input int ea, input int ev, input int ei);
        DrawX = 10'(x); DrawY = 10'(y); ram_data = 4'(d);
        @(posedge Clk); #1;
        check({tag, "_addr"}, 32'(ram_addr), 32'(ea));
        @(posedge Clk); #1;
        check({tag, "_valid"}, 32'(pix_valid), 32'(ev));
        check({tag, "_idx"}, 32'(pix_idx), 32'(ei));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int exp_left;
        Reset_n = 1'b0; frame_start = 1'b0; DrawX = '0; DrawY = '0;
        SpriteX = '0; SpriteY = '0; dir = '0; moving = 1'b0; ram_data = '0;
        #12;
        check("rst_addr", 32'(ram_addr), 32'd0);
        check("rst_valid", 32'(pix_valid), 32'd0);
        check("rst_idx", 32'(pix_idx), 32'd0);
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        SpriteX = 10'd100; SpriteY = 10'd50; dir = 2'd0;
        pulse();
        probe("t1_hit", 100, 50, 5, 0, 1, 5);
        probe("t1_off", 103, 52, 9, 131, 1, 9);

        probe("t2_left", 99, 50, 5, 0, 0, 0);
        probe("t2_right", 116, 50, 5, 0, 0, 0);
        probe("t2_corner", 115, 65, 5, 975, 1, 5);
        probe("t2_below", 100, 66, 5, 0, 0, 0);
        probe("t2_transp", 101, 50, 0, 1, 0, 0);

        moving = 1'b1;
        repeat (7) pulse();
        probe("t3_p7", 100, 50, 5, 0, 1, 5);
        pulse();
        probe("t3_p8", 100, 50, 5, 16, 1, 5);
        repeat (16) pulse();
        probe("t3_p24", 100, 50, 5, 48, 1, 5);
        repeat (8) pulse();
        probe("t3_p32", 100, 50, 5, 0, 1, 5);
        moving = 1'b0;
        repeat (5) pulse();
        probe("t3_hold", 100, 50, 5, 0, 1, 5);
        moving = 1'b1;
        repeat (7) pulse();
        probe("t3_divhold", 100, 50, 5, 0, 1, 5);
        pulse();
        probe("t3_step", 100, 50, 5, 16, 1, 5);
        moving = 1'b0;

        SpriteX = 10'd200;
        probe("t4_old", 100, 50, 5, 16, 1, 5);
        probe("t4_newpre", 200, 50, 5, 0, 0, 0);
        pulse();
        probe("t4_new", 200, 50, 5, 16, 1, 5);
        probe("t4_oldpost", 100, 50, 5, 0, 0, 0);

        SpriteX = 10'd630;
        pulse();
        probe("e_645", 645, 50, 5, 31, 1, 5);
        probe("e_646", 646, 50, 5, 0, 0, 0);
        probe("e_630", 630, 50, 3, 16, 1, 3);

        SpriteX = 10'd1020;
        pulse();
        probe("w_0", 0, 50, 5, 0, 0, 0);
        probe("w_3", 3, 50, 5, 0, 0, 0);
        probe("w_1023", 1023, 50, 5, 19, 1, 5);

        SpriteX = 10'd100; DrawX = 10'd1020; DrawY = 10'd50; ram_data = 4'd5;
        pulse();
        check("fs_old_addr", 32'(ram_addr), 32'd16);
        @(posedge Clk); #1;
        check("fs_new_addr", 32'(ram_addr), 32'd0);
        check("fs_old_valid", 32'(pix_valid), 32'd1);

`ifdef SPRITE_MIRROR_EN
        exp_left = 221;
`else
        exp_left = 2258;
`endif
        dir = 2'd2;
        pulse();
        probe("t5_left", 102, 53, 5, exp_left, 1, 5);
        dir = 2'd3;
        pulse();
        probe("t5_down", 102, 53, 5, 3282, 1, 5);
        dir = 2'd1;
        pulse();
        probe("t5_up", 102, 53, 5, 1234, 1, 5);

        dir = 2'd0;
        pulse();
        DrawX = 10'd103; DrawY = 10'd50; ram_data = 4'd5;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check("t6_pre_valid", 32'(pix_valid), 32'd1);
        check("t6_pre_addr", 32'(ram_addr), 32'd19);
        #2 Reset_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(pix_valid), 32'd0);
        check("t6_async_idx", 32'(pix_idx), 32'd0);
        check("t6_async_addr", 32'(ram_addr), 32'd0);
        #2 Reset_n = 1'b1;
        DrawX = 10'd5; DrawY = 10'd5; ram_data = 4'd5;
        @(posedge Clk); #1;
        check("t6_anim0_addr", 32'(ram_addr), 32'd325);
        check("t6_fill_valid", 32'(pix_valid), 32'd0);
        @(posedge Clk); #1;
        check("t6_refill_valid", 32'(pix_valid), 32'd1);
        check("t6_refill_idx", 32'(pix_idx), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
